// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input-conditioning (debounce) block.
package input_cond_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_t;

    // Bits needed to hold a count running from 0 up to db_cycles.
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, qualify FSM with stability counter, edge pulses.
// Edge pulses exist only when INPUT_DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are tied low.
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
    // Count value on which the DB_CYCLES-th consecutive differing clock is seen.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             db_nxt;

    // Synchroniser: raw is touched by nothing but the first flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db    <= db_nxt;
        end
    end

    // Any clock where sync_q matches db again throws away the partial count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (sync_q != db) begin
                    if (DB_CYCLES == 1) begin
                        db_nxt = sync_q;
                    end else begin
                        state_nxt = ST_PENDING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (sync_q == db) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    db_nxt    = sync_q;
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef INPUT_DEBOUNCE_EDGE_EN
    logic db_d;

    // Pulses land in the clock after db changes and last exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_d <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            db_d <= db;
            rise <= db & ~db_d;
            fall <= ~db & db_d;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// N_CH-wide synchronise-and-debounce stage for raw buttons/switches.
// Define INPUT_DEBOUNCE_EDGE_EN to enable the btn_rise/btn_fall pulse outputs.
module input_debounce
    import input_cond_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 120000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_db,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
);

    if (SYNC_STAGES < 2 || DB_CYCLES == 0) begin : g_bad_cfg
        $error("input_debounce: need SYNC_STAGES>=2 and DB_CYCLES>=1");
    end

    // Channels share nothing but clock and reset.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[ch]),
            .db   (btn_db[ch]),
            .rise (btn_rise[ch]),
            .fall (btn_fall[ch])
        );
    end

endmodule
